ttt_game_ctrl: RTL and testbench
================================

// Module: ttt_game_ctrl
// PURPOSE
//  Tic-tac-toe game sequencer that drives the board video generator. It holds two 9-bit
//  occupancy boards (X and O), a cursor and a turn flag, and accepts move/select buttons.
//  It runs a per-turn timeout, detects win/draw, and presents board state to the VGA path.
//  It sits between the debounced button inputs and the video generator.
//  Cell index i = row*3 + col, where row, col are in 0..2.
// PARAMETERS
//  TURN_CYCLES  250_000_000  clocks allowed per turn (10 s at 25 MHz); must be >= 2
//  TIMER_W      28           width of turn timer; must satisfy TURN_CYCLES-1 < 2**TIMER_W
// PORTS
//  clk        in   1   system/pixel clock; only clock in the block
//  rst_n      in   1   reset, asynchronous assert, active-low
//  start      in   1   level, sync to clk; rising edge starts a new game
//  btn_move   in   1   level, sync to clk; rising edge advances the cursor
//  btn_sel    in   1   level, sync to clk; rising edge places a piece at the cursor
//  matrix_x   out  9   X occupancy; bit i = cell i
//  matrix_o   out  9   O occupancy; bit i = cell i
//  cursor     out  4   selected cell, range 0..8
//  turn       out  1   player to move: 0 = X, 1 = O
//  game_over  out  1   high in WIN or DRAW
//  winner     out  2   00 none, 01 X, 10 O, 11 draw
//  sel_err    out  1   one-cycle pulse when a select hits an occupied cell
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; matrix_x, matrix_o, cursor, turn, game_over, winner, sel_err = 0.
//   - timer = 0. Edge-detect registers for start, btn_move, btn_sel = 0.
//   - Consequence: an input held high at reset release produces one edge.
//  Edge detect: e = in & ~in_q, where in_q is in registered one cycle. All actions use e only.
//  States: IDLE, TURN, CHECK, WIN, DRAW (registered FSM).
//   IDLE:
//    - start_e -> clear both boards, cursor=0, turn=0, timer=TURN_CYCLES-1, winner=00.
//    - Then go to TURN.
//   TURN: priority is sel_e > timeout > move_e. start_e is ignored.
//    - sel_e, cell free (~(x|o)[cursor]): set bit cursor in the board of turn; go to CHECK.
//    - sel_e, cell occupied: sel_err=1 for that cycle only; stay in TURN. Timer keeps running.
//    - timeout (timer==0, no sel_e): place at the lowest-index free cell; go to CHECK.
//      The cursor does not change.
//    - move_e: cursor = (cursor==8) ? 0 : cursor+1. Occupied cells are not skipped.
//    - Otherwise, timer decrements by 1 each cycle.
//   CHECK (exactly 1 cycle): evaluate only the board of the player who just moved.
//    - Win lines: rows {0,1,2} {3,4,5} {6,7,8}; columns {0,3,6} {1,4,7} {2,5,8};
//      diagonals {0,4,8} {2,4,6}.
//    - Any line full -> WIN, with winner = turn ? 10 : 01.
//    - Else if (x|o)==9'h1FF -> DRAW, winner=11. A win on the ninth move is a WIN, not a DRAW.
//    - Else turn=~turn, timer=TURN_CYCLES-1, go to TURN.
//   WIN / DRAW:
//    - game_over=1; boards, cursor and winner are held. All buttons are ignored except start_e.
//    - start_e behaves as in IDLE (new game).
//  Latency: sel_e in cycle N -> matrix_* updated at N+1 -> game_over/winner/turn valid at N+2.
//   Next accepted sel_e is no earlier than N+2.
//  Invariant: (matrix_x & matrix_o) == 0 at all times.
//  Mid-game reset: rst_n low aborts immediately; all outputs go to their reset values.
// TESTING
//  1. Reset, start pulse; sel at cursor 0 -> matrix_x=001h, turn=1 after 2 clocks.
//  2. X plays 0,4,8; O plays 1,2 via move/sel -> winner=01, game_over=1.
//     Further sel/move leaves matrix unchanged.
//  3. Sel on occupied cell 0 -> sel_err is high for exactly 1 cycle; boards and turn unchanged.
//  4. TURN_CYCLES=16, no input after start -> X auto-placed at cell 0 on cycle 16,
//     then O auto-placed at cell 1.
//  5. Move pressed 9 times from 0 -> cursor walks 1..8 then wraps to 0.
//     Move and sel in the same cycle -> piece placed at the old cursor; cursor not advanced.
//  6. Play to a full board with no line -> winner=11. Start -> boards=0, turn=0, winner=00.
//     rst_n pulse mid-game -> all outputs 0.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the X/O boards, cursor, turn and per-turn timer,
// and presents board and result state to the video generator.
module ttt_game_ctrl #(
    parameter int unsigned TURN_CYCLES = 250_000_000,
    parameter int unsigned TIMER_W     = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               btn_move,
    input  logic               btn_sel,
    output logic [8:0]         matrix_x,
    output logic [8:0]         matrix_o,
    output logic [3:0]         cursor,
    output logic               turn,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               sel_err
);

    localparam int unsigned CELLS = 9;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [3:0]         LAST_CELL  = 4'd8;
    localparam logic [CELLS-1:0]   FULL_BOARD = 9'h1FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_CHECK,
        S_WIN,
        S_DRAW
    } state_t;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               start_q, move_q, sel_q;
    logic [CELLS-1:0]   matrix_x_nxt, matrix_o_nxt;
    logic [3:0]         cursor_nxt;
    logic               turn_nxt, game_over_nxt, sel_err_nxt;
    logic [1:0]         winner_nxt;

    logic               start_e, move_e, sel_e;
    logic [CELLS-1:0]   occupied, free_cells, lowest_free, cursor_bit, mover_board;

    function automatic logic has_line(input logic [CELLS-1:0] b);
        has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
                   (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
                   (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    assign start_e     = start & ~start_q;
    assign move_e      = btn_move & ~move_q;
    assign sel_e       = btn_sel & ~sel_q;
    assign occupied    = matrix_x | matrix_o;
    assign free_cells  = ~occupied;
    // Isolate the lowest set bit: the auto-placement target on timeout.
    assign lowest_free = free_cells & (~free_cells + 9'd1);
    assign cursor_bit  = 9'b1 << cursor;
    assign mover_board = turn ? matrix_o : matrix_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            start_q   <= 1'b0;
            move_q    <= 1'b0;
            sel_q     <= 1'b0;
            matrix_x  <= '0;
            matrix_o  <= '0;
            cursor    <= '0;
            turn      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            start_q   <= start;
            move_q    <= btn_move;
            sel_q     <= btn_sel;
            matrix_x  <= matrix_x_nxt;
            matrix_o  <= matrix_o_nxt;
            cursor    <= cursor_nxt;
            turn      <= turn_nxt;
            game_over <= game_over_nxt;
            winner    <= winner_nxt;
            sel_err   <= sel_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        matrix_x_nxt = matrix_x;
        matrix_o_nxt = matrix_o;
        cursor_nxt   = cursor;
        turn_nxt     = turn;
        winner_nxt   = winner;
        sel_err_nxt  = 1'b0;

        case (state)
            S_IDLE, S_WIN, S_DRAW: begin
                if (start_e) begin
                    matrix_x_nxt = '0;
                    matrix_o_nxt = '0;
                    cursor_nxt   = '0;
                    turn_nxt     = 1'b0;
                    timer_nxt    = TIMER_LOAD;
                    winner_nxt   = 2'b00;
                    state_nxt    = S_TURN;
                end
            end
            S_TURN: begin
                if (sel_e) begin
                    if ((occupied & cursor_bit) == '0) begin
                        if (turn) matrix_o_nxt = matrix_o | cursor_bit;
                        else      matrix_x_nxt = matrix_x | cursor_bit;
                        state_nxt = S_CHECK;
                    end else begin
                        sel_err_nxt = 1'b1;
                        if (timer != '0) timer_nxt = timer - TIMER_W'(1);
                    end
                end else if (timer == '0) begin
                    if (turn) matrix_o_nxt = matrix_o | lowest_free;
                    else      matrix_x_nxt = matrix_x | lowest_free;
                    state_nxt = S_CHECK;
                end else begin
                    if (move_e) cursor_nxt = (cursor == LAST_CELL) ? 4'd0 : cursor + 4'd1;
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            S_CHECK: begin
                // Only the player who just moved can have completed a line.
                if (has_line(mover_board)) begin
                    winner_nxt = turn ? 2'b10 : 2'b01;
                    state_nxt  = S_WIN;
                end else if (occupied == FULL_BOARD) begin
                    winner_nxt = 2'b11;
                    state_nxt  = S_DRAW;
                end else begin
                    turn_nxt  = ~turn;
                    timer_nxt = TIMER_LOAD;
                    state_nxt = S_TURN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        game_over_nxt = (state_nxt == S_WIN) || (state_nxt == S_DRAW);
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: play, errors, wrap, draw, reset, and timeout auto-placement.
module tb_ttt_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, btn_move, btn_sel;
    logic [8:0] mx, mo;
    logic [3:0] cursor;
    logic       turn, game_over, sel_err;
    logic [1:0] winner;

    logic       rst_n_t, start_t;
    logic [8:0] t_mx, t_mo;
    logic [3:0] t_cursor;
    logic       t_turn, t_game_over, t_sel_err;
    logic [1:0] t_winner;

    int tests  = 0;
    int failed = 0;
    int cur    = 0;

    always #5 clk = ~clk;

    ttt_game_ctrl #(.TURN_CYCLES(64), .TIMER_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn_move(btn_move), .btn_sel(btn_sel),
        .matrix_x(mx), .matrix_o(mo), .cursor(cursor), .turn(turn),
        .game_over(game_over), .winner(winner), .sel_err(sel_err)
    );

    ttt_game_ctrl #(.TURN_CYCLES(16), .TIMER_W(5)) dut_t (
        .clk(clk), .rst_n(rst_n_t), .start(start_t), .btn_move(1'b0), .btn_sel(1'b0),
        .matrix_x(t_mx), .matrix_o(t_mo), .cursor(t_cursor), .turn(t_turn),
        .game_over(t_game_over), .winner(t_winner), .sel_err(t_sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press_start();
        start = 1'b1; tick();
        start = 1'b0; tick();
        cur = 0;
    endtask

    task automatic press_move();
        btn_move = 1'b1; tick();
        btn_move = 1'b0; tick();
        cur = (cur == 8) ? 0 : cur + 1;
    endtask

    task automatic press_sel();
        btn_sel = 1'b1; tick();
        btn_sel = 1'b0; tick();
    endtask

    task automatic play(input int target);
        while (cur != target) press_move();
        chk("cursor_before_sel", 32'(cursor), 32'(target));
        press_sel();
        chk("no_overlap", 32'(mx & mo), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; btn_move = 1'b0; btn_sel = 1'b0;
        rst_n_t = 1'b0; start_t = 1'b0;
        tick(); tick();
        chk("rst_mx", 32'(mx), 32'd0);
        chk("rst_mo", 32'(mo), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_turn", 32'(turn), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // First move: X at cell 0, result visible two clocks after the select edge
        press_start();
        btn_sel = 1'b1; tick();
        chk("t1_mx_n1", 32'(mx), 32'h001);
        chk("t1_turn_n1", 32'(turn), 32'd0);
        btn_sel = 1'b0; tick();
        chk("t1_turn_n2", 32'(turn), 32'd1);
        chk("t1_game_over", 32'(game_over), 32'd0);

        // O selects occupied cell 0
        btn_sel = 1'b1; tick();
        chk("t3_sel_err_hi", 32'(sel_err), 32'd1);
        chk("t3_mx", 32'(mx), 32'h001);
        chk("t3_mo", 32'(mo), 32'h000);
        btn_sel = 1'b0; tick();
        chk("t3_sel_err_lo", 32'(sel_err), 32'd0);
        chk("t3_turn", 32'(turn), 32'd1);
        tick();
        chk("t3_sel_err_still_lo", 32'(sel_err), 32'd0);

        // X wins on the 0-4-8 diagonal
        play(1);
        chk("t2_mo_1", 32'(mo), 32'h002);
        chk("t2_turn_x", 32'(turn), 32'd0);
        play(4);
        chk("t2_mx_04", 32'(mx), 32'h011);
        play(2);
        chk("t2_mo_12", 32'(mo), 32'h006);
        play(8);
        chk("t2_mx_win", 32'(mx), 32'h111);
        chk("t2_winner", 32'(winner), 32'd1);
        chk("t2_game_over", 32'(game_over), 32'd1);
        press_move();
        press_sel();
        chk("t2_hold_mx", 32'(mx), 32'h111);
        chk("t2_hold_mo", 32'(mo), 32'h006);
        chk("t2_hold_cursor", 32'(cursor), 32'd8);
        chk("t2_hold_winner", 32'(winner), 32'd1);
        cur = 8;

        // New game from WIN, cursor walk and wrap
        press_start();
        chk("t5_clear_mx", 32'(mx), 32'd0);
        chk("t5_clear_winner", 32'(winner), 32'd0);
        chk("t5_clear_go", 32'(game_over), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            press_move();
            chk("t5_cursor_walk", 32'(cursor), 32'(i % 9));
        end
        btn_move = 1'b1; btn_sel = 1'b1; tick();
        chk("t5_both_mx", 32'(mx), 32'h001);
        chk("t5_both_cursor", 32'(cursor), 32'd0);
        btn_move = 1'b0; btn_sel = 1'b0; tick();
        chk("t5_both_turn", 32'(turn), 32'd1);

        // Draw: X {0,1,5,6,8}, O {2,3,4,7}
        play(2); play(1); play(3); play(5); play(4); play(6);
        chk("t6_mid_game_over", 32'(game_over), 32'd0);
        play(7); play(8);
        chk("t6_mx", 32'(mx), 32'h163);
        chk("t6_mo", 32'(mo), 32'h09C);
        chk("t6_winner", 32'(winner), 32'd3);
        chk("t6_game_over", 32'(game_over), 32'd1);
        press_start();
        chk("t6_new_mx", 32'(mx), 32'd0);
        chk("t6_new_mo", 32'(mo), 32'd0);
        chk("t6_new_turn", 32'(turn), 32'd0);
        chk("t6_new_winner", 32'(winner), 32'd0);

        // Mid-game asynchronous reset
        play(0);
        press_move();
        chk("t6_pre_rst_cursor", 32'(cursor), 32'd1);
        chk("t6_pre_rst_turn", 32'(turn), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mx", 32'(mx), 32'd0);
        chk("t6_rst_cursor", 32'(cursor), 32'd0);
        chk("t6_rst_turn", 32'(turn), 32'd0);
        tick();
        rst_n = 1'b1;

        // Timeout auto-placement with TURN_CYCLES = 16
        rst_n_t = 1'b1;
        tick();
        start_t = 1'b1; tick();
        start_t = 1'b0;
        repeat (15) tick();
        chk("t4_mx_before", 32'(t_mx), 32'd0);
        tick();
        chk("t4_mx_auto", 32'(t_mx), 32'h001);
        chk("t4_turn_pre", 32'(t_turn), 32'd0);
        tick();
        chk("t4_turn_o", 32'(t_turn), 32'd1);
        repeat (15) tick();
        chk("t4_mo_before", 32'(t_mo), 32'd0);
        tick();
        chk("t4_mo_auto", 32'(t_mo), 32'h002);
        chk("t4_mx_kept", 32'(t_mx), 32'h001);
        chk("t4_cursor", 32'(t_cursor), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
